muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide execution unit for the pipelined CPU. It sits beside the EX-stage ALU and services the two-bit multiDiv function field. Results are full double-width: the low half goes to the destination register and the high half/remainder goes to R0, matching the existing result/overflow pair. It uses a start/busy/done handshake so the hazard logic can stall IF/ID/EX while it runs, and a flush input so a taken branch can abort an in-flight operation.

Parameters:
WIDTH, 16, operand width in bits (≥4); results are WIDTH bits each, product is 2*WIDTH.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when unit is idle-or-done
op  input  2  00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div
flush  input  1  abort in-flight operation (pipeline flush)
operand_a  input  WIDTH  multiplicand / dividend
operand_b  input  WIDTH  multiplier / divisor
busy  output  1  operation in progress (CALC or FIX)
done  output  1  one-cycle pulse, results valid and updated
result_lo  output  WIDTH  product low half / quotient
result_hi  output  WIDTH  product high half / remainder (R0 write data)
div_by_zero  output  1  sticky-until-next-done flag for divide with operand_b==0

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, div_by_zero=0, result_lo=0, result_hi=0, counter=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start=1 at edge E0: latch op, operand_a, operand_b; convert signed operands to magnitudes and record result signs; counter=0; go to CALC. A start in DONE is accepted, so back-to-back issue is allowed.
- CALC: one shift-add (mul) or restoring shift-subtract (div) step per edge. Exactly WIDTH edges (E1..E_WIDTH), then go to FIX.
- FIX (edge E_WIDTH+1): apply sign correction, write result_lo/result_hi, set div_by_zero, go to DONE.
- DONE: done=1 for exactly one cycle. Next edge goes to IDLE, or to CALC if start=1.
- Latency: done is high in the cycle following edge E0+WIDTH+1. For WIDTH=16, that is 17 edges after start is sampled. Latency is fixed and does not depend on data.
- busy=1 in CALC and FIX only. start while busy=1 is ignored; no queueing.
- Results hold their value until the next FIX. They are unaffected by flush and by operand changes after E0.
- Signed mul: exact 2*WIDTH two's-complement product split hi:lo.
- Unsigned div: quotient in lo, remainder in hi.
- Signed div:
  - quotient truncates toward zero;
  - remainder takes the sign of the dividend;
  - MIN_INT / -1 gives lo=MIN_INT, hi=0, with no flag.
- Divide by zero (op[1]=1, operand_b=0): lo=all ones, hi=operand_a (unmodified, any signedness), div_by_zero=1. Timing is identical to a normal divide.
- div_by_zero is cleared at the FIX of any non-div-by-zero operation.
- flush=1 in CALC or FIX: next edge goes to IDLE; busy drops and no done is produced. Results and div_by_zero are unchanged.
- flush=1 together with start in IDLE/DONE: flush wins and the start is dropped.
- flush=1 in DONE: done is still shown this cycle. Next state is IDLE and any start is dropped.
- Reset asserted mid-operation clears everything immediately. No done is produced.

Test Plan:
- WIDTH=16, op=00, a=0x1234, b=0x5678, start 1 cycle -> busy for 17 cycles, done 1 cycle, then hi=0x0626, lo=0x0060, div_by_zero=0.
- op=01, a=0xFFFE, b=0x0003 -> hi=0xFFFF, lo=0xFFFA. Then op=11, a=0xFFF9 (-7), b=0x0002 -> lo=0xFFFD, hi=0xFFFF.
- op=10, a=100, b=7 -> lo=0x000E, hi=0x0002. Issue the next start during the DONE cycle -> second done exactly 18 cycles after the first, with no gap cycle lost.
- op=10, a=0x1234, b=0 -> lo=0xFFFF, hi=0x1234, div_by_zero=1. Then op=11, a=0x8000, b=0xFFFF -> lo=0x8000, hi=0x0000, div_by_zero=0.
- Start a mul, assert flush at CALC cycle 5 -> busy=0 the next cycle, no done, prior results unchanged. Start held high while busy -> ignored.
- Assert reset mid-CALC -> all outputs 0 asynchronously. After release, a new op completes with nominal latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit beside the EX-stage ALU: shift-add multiply and
// restoring divide over WIDTH steps, then one sign-fix step, with double-width results.
module muldiv_unit #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg
);
    // Handshake: start is taken only in IDLE or DONE (and not under flush); busy is
    // high through CALC and FIX; done pulses for one cycle when the results update.
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    state_t                 state, next_state;
    logic [CNT_W-1:0]       cnt;
    logic [1:0]             op_q;
    logic [WIDTH-1:0]       a_raw, mag_a, mag_b;
    logic [2*WIDTH-1:0]     p, p_step;
    logic                   neg_lo, neg_hi, b_zero;
    logic                   accept;
    logic                   sign_a, sign_b;
    logic [WIDTH:0]         add_sum, div_shift, div_diff;
    logic                   div_ge;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_fix, rem_fix;

    assign accept = (state == IDLE || state == DONE) && start && !flush;
    assign sign_a = op[0] & operand_a[WIDTH-1];
    assign sign_b = op[0] & operand_b[WIDTH-1];

    // One iteration: hi half is the running partial product / remainder.
    always_comb begin
        add_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mag_a} : '0);
        div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        div_ge    = (div_shift >= {1'b0, mag_b});
        if (op_q[1])
            p_step = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), p[WIDTH-2:0], div_ge};
        else
            p_step = {add_sum, p[WIDTH-1:1]};
        prod_fix = neg_lo ? -p : p;
        quo_fix  = neg_lo ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        rem_fix  = neg_hi ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: next_state = accept ? CALC : IDLE;
            CALC: begin
                if (flush)                          next_state = IDLE;
                else if (cnt == CNT_W'(WIDTH - 1))  next_state = FIX;
                else                                next_state = CALC;
            end
            FIX:     next_state = flush ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == CALC) || (state == FIX);
        done      = (state == DONE);
        state_dbg = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            op_q        <= '0;
            a_raw       <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            p           <= '0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            b_zero      <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                cnt    <= '0;
                op_q   <= op;
                a_raw  <= operand_a;
                mag_a  <= sign_a ? -operand_a : operand_a;
                mag_b  <= sign_b ? -operand_b : operand_b;
                neg_lo <= sign_a ^ sign_b;
                neg_hi <= op[1] ? sign_a : (sign_a ^ sign_b);
                b_zero <= (operand_b == '0);
                // Multiply seeds the low half with the multiplier, divide with the dividend.
                p      <= {{WIDTH{1'b0}}, (op[1] ? (sign_a ? -operand_a : operand_a)
                                                 : (sign_b ? -operand_b : operand_b))};
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                p   <= p_step;
            end else if (state == FIX && !flush) begin
                if (op_q[1] && b_zero) begin
                    result_lo   <= '1;
                    result_hi   <= a_raw;
                    div_by_zero <= 1'b1;
                end else if (op_q[1]) begin
                    result_lo   <= quo_fix;
                    result_hi   <= rem_fix;
                    div_by_zero <= 1'b0;
                end else begin
                    result_lo   <= prod_fix[WIDTH-1:0];
                    result_hi   <= prod_fix[2*WIDTH-1:WIDTH];
                    div_by_zero <= 1'b0;
                end
            end
        end
    end
endmodule
